alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Downstream neighbour of the 8-bit ALU: accepts ALU result plus NZVC flags, buffers them in a 2-entry skid FIFO, and commits them in order into an 8-entry register file and a status-flags register.
- The register file's two read ports feed the ALU operand inputs. A hazard output lets the issue logic stall while an uncommitted write targets a register being read.

Parameters:
- DATA_WIDTH, 8, width of result, register entries and read data
- REG_COUNT, 8, number of architectural registers; register 0 is hardwired to zero
- ADDR_WIDTH, 3, register address width (log2 REG_COUNT)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  ALU result valid
- inReady  output  1  stage can accept (occupancy < 2)
- aluResult  input  DATA_WIDTH  ALU result
- aluFlags  input  4  flags [3]C [2]V [1]Z [0]N
- destAddr  input  ADDR_WIDTH  destination register
- writeReg  input  1  commit result to register file
- writeFlags  input  1  commit aluFlags to flags register
- commitEnable  input  1  commit permitted this cycle (0 = writeback stalled)
- readAddrA  input  ADDR_WIDTH  read port A address
- readAddrB  input  ADDR_WIDTH  read port B address
- readDataA  output  DATA_WIDTH  read port A data, combinational
- readDataB  output  DATA_WIDTH  read port B data, combinational
- statusFlags  output  4  committed NZVC register
- hazard  output  1  uncommitted write pending to readAddrA/B
- occupancy  output  2  buffered entries, 0..2
- commitCount  output  8  number of committed entries, wraps

Behaviour:
- Reset (async, rst_n=0):
  - All registers = 0, statusFlags = 0, occupancy = 0, commitCount = 0.
  - inReady = 1 and hazard = 0 while in reset and after it.
  - Reset mid-operation discards buffered entries immediately.
- Accept:
  - Accept occurs on a rising edge when inValid && inReady; the entry {aluResult, aluFlags, destAddr, writeReg, writeFlags} is appended at the tail.
  - inReady = (occupancy != 2), decoded combinationally from registered occupancy only; there is no path from inValid to inReady.
- Commit:
  - Commit occurs on a rising edge when occupancy != 0 && commitEnable. The head entry is retired in FIFO order.
  - If head.writeReg and head.destAddr != 0, write regfile[destAddr] = result. A write to address 0 is dropped.
  - If head.writeFlags, statusFlags = head.flags; otherwise statusFlags holds.
  - commitCount increments on every commit, including entries with no writes, and wraps 255 -> 0.
- Occupancy transitions:
  - Accept only: +1.
  - Commit only: -1.
  - Accept and commit in the same cycle: unchanged, and order is preserved (new entry becomes head once the old head retires).
  - Occupancy 0 with accept and commitEnable: the entry is buffered, not committed in the same cycle (one-cycle minimum latency, accept -> commit).
  - Occupancy 2: no accept; a commit frees a slot and inReady=1 the next cycle.
- Read ports:
  - Address 0 returns 0.
  - Otherwise returns the register value, except bypass: if a commit writing the same address occurs this cycle, return the head result (write-first).
- Hazard:
  - hazard = 1 if any buffered entry with writeReg=1 and destAddr != 0 matches a nonzero readAddrA or readAddrB.
  - An entry committing this cycle is still counted in hazard; the bypass makes its data correct, but hazard stays conservative.
- Widths: all data is DATA_WIDTH with no extension or truncation. The flags field is exactly 4 bits, in the ALU's N, Z, V, C bit order.

Test Plan:
- Reset: drive rst_n=0 mid-stream with occupancy=2 -> occupancy=0, inReady=1, readDataA=0 for every address, statusFlags=0, commitCount=0 (all asynchronously).
- Basic commit: accept {0x3C, flags 4'b0000, dest 3, writeReg=1, writeFlags=1} with commitEnable=1 -> commit one cycle later; regfile[3]=0x3C, statusFlags=0; readAddrA=3 -> 0x3C.
- Backpressure: commitEnable=0, offer 3 entries (0x11→r1, 0x22→r2, 0x33→r3) -> third stalls with inReady=0 and occupancy=2. Then raise commitEnable -> commits r1, r2, r3 in order and commitCount=3.
- Register 0 and flags hold: entry 0xFF→r0 with writeReg=1, writeFlags=0, flags 4'b1001 -> readDataA(0)=0, statusFlags unchanged, commitCount still increments.
- Hazard and bypass:
  - Entry 0x80→r5 buffered with readAddrB=5 and commitEnable=0 -> hazard=1, readDataB = old r5.
  - Set commitEnable=1 -> readDataB=0x80 in the commit cycle.
  - Next cycle hazard=0 and readDataB=0x80.
- Wrap: perform 256 commits -> commitCount returns to 0. Simultaneous accept+commit at occupancy 1 for 10 cycles -> occupancy stays 1 and order is preserved.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Buffers ALU results (with NZVC flags) in a 2-entry skid FIFO and retires
// them in order into an 8-entry register file and a status-flags register.
// The register file read ports bypass a same-cycle commit (write-first), and
// a conservative hazard flag reports any buffered write to a read address.
module alu_writeback_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [3:0]            aluFlags,
  input  logic [ADDR_WIDTH-1:0] destAddr,
  input  logic                  writeReg,
  input  logic                  writeFlags,
  input  logic                  commitEnable,
  input  logic [ADDR_WIDTH-1:0] readAddrA,
  input  logic [ADDR_WIDTH-1:0] readAddrB,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic [DATA_WIDTH-1:0] readDataB,
  output logic [3:0]            statusFlags,
  output logic                  hazard,
  output logic [1:0]            occupancy,
  output logic [7:0]            commitCount
);

  // Skid FIFO storage, two slots addressed by a 1-bit head pointer
  logic [DATA_WIDTH-1:0] r_fifoData  [2];
  logic [3:0]            r_fifoFlags [2];
  logic [ADDR_WIDTH-1:0] r_fifoDest  [2];
  logic                  r_fifoWReg  [2];
  logic                  r_fifoWFlg  [2];
  logic                  r_head;
  logic [1:0]            r_occ;

  // Architectural state
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [3:0]            r_status;
  logic [7:0]            r_commitCount;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_tail;
  logic                  w_headWritesReg;
  logic                  w_slotValid [2];
  logic                  w_hazard;
  logic [DATA_WIDTH-1:0] w_readA;
  logic [DATA_WIDTH-1:0] w_readB;

  // Handshake decode: inReady depends only on registered occupancy, so there
  // is no combinational path from inValid back to inReady.
  always_comb begin
    inReady         = (r_occ != 2'd2);
    w_accept        = inValid && (r_occ != 2'd2);
    w_commit        = (r_occ != 2'd0) && commitEnable;
    w_tail          = r_head ^ r_occ[0];
    w_headWritesReg = r_fifoWReg[r_head] && (r_fifoDest[r_head] != '0);
  end

  // Entry storage: a new entry lands in the slot just past the buffered ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifoData[i]  <= '0;
        r_fifoFlags[i] <= '0;
        r_fifoDest[i]  <= '0;
        r_fifoWReg[i]  <= 1'b0;
        r_fifoWFlg[i]  <= 1'b0;
      end
    end else if (w_accept) begin
      r_fifoData[w_tail]  <= aluResult;
      r_fifoFlags[w_tail] <= aluFlags;
      r_fifoDest[w_tail]  <= destAddr;
      r_fifoWReg[w_tail]  <= writeReg;
      r_fifoWFlg[w_tail]  <= writeFlags;
    end
  end

  // Head pointer and occupancy; simultaneous accept and commit leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_commit) begin
        r_head <= ~r_head;
      end
      case ({w_accept, w_commit})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Register file writes from the retiring head; register 0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_headWritesReg) begin
      r_regs[r_fifoDest[r_head]] <= r_fifoData[r_head];
    end
  end

  // Status flags and the wrapping commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status      <= 4'd0;
      r_commitCount <= 8'd0;
    end else if (w_commit) begin
      if (r_fifoWFlg[r_head]) begin
        r_status <= r_fifoFlags[r_head];
      end
      r_commitCount <= r_commitCount + 8'd1;
    end
  end

  // Read ports: zero register, then write-first bypass of a commit this cycle
  always_comb begin
    w_readA = r_regs[readAddrA];
    if (readAddrA == '0) begin
      w_readA = '0;
    end else if (w_commit && w_headWritesReg && (r_fifoDest[r_head] == readAddrA)) begin
      w_readA = r_fifoData[r_head];
    end
    w_readB = r_regs[readAddrB];
    if (readAddrB == '0) begin
      w_readB = '0;
    end else if (w_commit && w_headWritesReg && (r_fifoDest[r_head] == readAddrB)) begin
      w_readB = r_fifoData[r_head];
    end
  end

  // Slot validity from head and occupancy
  always_comb begin
    w_slotValid[0] = (r_occ == 2'd2) || ((r_occ == 2'd1) && !r_head);
    w_slotValid[1] = (r_occ == 2'd2) || ((r_occ == 2'd1) && r_head);
  end

  // Hazard: any buffered register write (including one retiring now) to a live read address
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (w_slotValid[i] && r_fifoWReg[i] && (r_fifoDest[i] != '0)) begin
        if (((readAddrA != '0) && (r_fifoDest[i] == readAddrA)) ||
            ((readAddrB != '0) && (r_fifoDest[i] == readAddrB))) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  assign readDataA   = w_readA;
  assign readDataB   = w_readB;
  assign hazard      = w_hazard;
  assign statusFlags = r_status;
  assign occupancy   = r_occ;
  assign commitCount = r_commitCount;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage
// Directed stimulus against alu_writeback_stage, checked every cycle against
// a queue-based model of the writeback stage plus hand-computed literals.
module tb_alu_writeback_stage;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       inReady;
  logic [7:0] aluResult;
  logic [3:0] aluFlags;
  logic [2:0] destAddr;
  logic       writeReg;
  logic       writeFlags;
  logic       commitEnable;
  logic [2:0] readAddrA;
  logic [2:0] readAddrB;
  logic [7:0] readDataA;
  logic [7:0] readDataB;
  logic [3:0] statusFlags;
  logic       hazard;
  logic [1:0] occupancy;
  logic [7:0] commitCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
    logic [2:0] dest;
    logic       wreg;
    logic       wflg;
  } entry_t;

  entry_t     mq[$];
  logic [7:0] mRegs [8];
  logic [3:0] mStatus;
  logic [7:0] mCount;

  alu_writeback_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inValid      (inValid),
    .inReady      (inReady),
    .aluResult    (aluResult),
    .aluFlags     (aluFlags),
    .destAddr     (destAddr),
    .writeReg     (writeReg),
    .writeFlags   (writeFlags),
    .commitEnable (commitEnable),
    .readAddrA    (readAddrA),
    .readAddrB    (readAddrB),
    .readDataA    (readDataA),
    .readDataB    (readDataB),
    .statusFlags  (statusFlags),
    .hazard       (hazard),
    .occupancy    (occupancy),
    .commitCount  (commitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] f,
                               input logic [2:0] a, input logic wr, input logic wf, input logic ce);
    inValid      = v;
    aluResult    = d;
    aluFlags     = f;
    destAddr     = a;
    writeReg     = wr;
    writeFlags   = wf;
    commitEnable = ce;
    @(posedge clk);
    #1;
  endtask

  // Retire the model's head entry into the model register file and flags
  task automatic modelCommit();
    if (mq[0].wreg && (mq[0].dest != 3'd0)) mRegs[mq[0].dest] <= mq[0].data;
    if (mq[0].wflg) mStatus <= mq[0].flags;
    mCount <= mCount + 8'd1;
    void'(mq.pop_front());
  endtask

  task automatic modelAccept();
    mq.push_back('{data: aluResult, flags: aluFlags, dest: destAddr, wreg: writeReg, wflg: writeFlags});
  endtask

  function automatic logic [7:0] expRead(input logic [2:0] addr);
    if (addr == 3'd0) return 8'd0;
    if (rst_n && (mq.size() != 0) && commitEnable && mq[0].wreg && (mq[0].dest == addr)) return mq[0].data;
    return mRegs[addr];
  endfunction

  function automatic logic expHazard();
    foreach (mq[i]) begin
      if (mq[i].wreg && (mq[i].dest != 3'd0) &&
          (((readAddrA != 3'd0) && (mq[i].dest == readAddrA)) ||
           ((readAddrB != 3'd0) && (mq[i].dest == readAddrB))))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural model: a queue of at most two entries, commit from the front, accept to the back
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mRegs[i] <= 8'd0;
      mStatus <= 4'd0;
      mCount  <= 8'd0;
    end else if (mq.size() == 0) begin
      if (inValid) modelAccept();
    end else if (mq.size() == 1) begin
      if (commitEnable) modelCommit();
      if (inValid) modelAccept();
    end else begin
      if (commitEnable) modelCommit();
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    checkOutput("cyc_inReady", inReady, (mq.size() != 2));
    checkOutput("cyc_occupancy", occupancy, mq.size());
    checkOutput("cyc_commitCount", commitCount, mCount);
    checkOutput("cyc_statusFlags", statusFlags, mStatus);
    checkOutput("cyc_hazard", hazard, expHazard());
    checkOutput("cyc_readDataA", readDataA, expRead(readAddrA));
    checkOutput("cyc_readDataB", readDataB, expRead(readAddrB));
  end

  initial begin
    rst_n        = 1'b0;
    inValid      = 1'b0;
    aluResult    = 8'd0;
    aluFlags     = 4'd0;
    destAddr     = 3'd0;
    writeReg     = 1'b0;
    writeFlags   = 1'b0;
    commitEnable = 1'b0;
    readAddrA    = 3'd0;
    readAddrB    = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_inReady", inReady, 1);
    checkOutput("rst_hazard", hazard, 0);
    rst_n = 1'b1;

    // Basic commit into r3
    readAddrA = 3'd3;
    applyStimulus(1'b1, 8'h3C, 4'b0000, 3'd3, 1'b1, 1'b1, 1'b1);
    checkOutput("basic_occ_after_accept", occupancy, 1);
    checkOutput("basic_hazard_pending", hazard, 1);
    applyStimulus(1'b0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("basic_readA_r3", readDataA, 8'h3C);
    checkOutput("basic_status", statusFlags, 4'b0000);
    checkOutput("basic_count", commitCount, 1);
    checkOutput("basic_occ_empty", occupancy, 0);

    // Backpressure with commits stalled
    applyStimulus(1'b1, 8'h11, 4'b0010, 3'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 4'b0001, 3'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_occ_full", occupancy, 2);
    checkOutput("bp_inReady_low", inReady, 0);
    applyStimulus(1'b1, 8'h33, 4'b1000, 3'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_occ_still_full", occupancy, 2);
    applyStimulus(1'b1, 8'h33, 4'b1000, 3'd3, 1'b1, 1'b1, 1'b1);
    checkOutput("bp_occ_after_r1", occupancy, 1);
    checkOutput("bp_status_r1", statusFlags, 4'b0010);
    applyStimulus(1'b1, 8'h33, 4'b1000, 3'd3, 1'b1, 1'b1, 1'b1);
    checkOutput("bp_status_r2_held", statusFlags, 4'b0010);
    applyStimulus(1'b0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_count", commitCount, 4);
    checkOutput("bp_status_r3", statusFlags, 4'b1000);
    readAddrA = 3'd1;
    readAddrB = 3'd2;
    #1;
    checkOutput("bp_r1", readDataA, 8'h11);
    checkOutput("bp_r2", readDataB, 8'h22);
    readAddrA = 3'd3;
    #1;
    checkOutput("bp_r3", readDataA, 8'h33);

    // Write to r0 is dropped, flags hold, count still advances
    readAddrA = 3'd0;
    applyStimulus(1'b1, 8'hFF, 4'b1001, 3'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("r0_readA", readDataA, 8'h00);
    checkOutput("r0_status_held", statusFlags, 4'b1000);
    checkOutput("r0_count", commitCount, 5);

    // Hazard and write-first bypass on r5
    readAddrB = 3'd5;
    applyStimulus(1'b1, 8'h55, 4'b0100, 3'd5, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h80, 4'b0001, 3'd5, 1'b1, 1'b0, 1'b0);
    inValid = 1'b0;
    #1;
    checkOutput("hz_pending", hazard, 1);
    checkOutput("hz_old_r5", readDataB, 8'h55);
    commitEnable = 1'b1;
    #1;
    checkOutput("hz_bypass_r5", readDataB, 8'h80);
    checkOutput("hz_still_set", hazard, 1);
    @(posedge clk);
    #1;
    checkOutput("hz_cleared", hazard, 0);
    checkOutput("hz_r5_committed", readDataB, 8'h80);
    checkOutput("hz_count", commitCount, 7);
    checkOutput("hz_status", statusFlags, 4'b0100);

    // Asynchronous reset with two entries buffered
    applyStimulus(1'b1, 8'hAA, 4'b1111, 3'd6, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hBB, 4'b1111, 3'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("mid_occ_full", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_occ", occupancy, 0);
    checkOutput("mid_rst_inReady", inReady, 1);
    checkOutput("mid_rst_status", statusFlags, 0);
    checkOutput("mid_rst_count", commitCount, 0);
    checkOutput("mid_rst_hazard", hazard, 0);
    for (int a = 0; a < 8; a++) begin
      readAddrA = a[2:0];
      #1;
      checkOutput("mid_rst_readA", readDataA, 8'h00);
    end
    inValid      = 1'b0;
    commitEnable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming accept+commit for 256 entries: counter wraps back to zero
    for (int i = 0; i < 256; i++) begin
      readAddrA = 3'(i + 1);
      readAddrB = i[2:0];
      applyStimulus(1'b1, i[7:0] ^ 8'h5A, i[3:0], i[2:0], 1'b1, i[0], 1'b1);
      if (i >= 1 && i <= 10) checkOutput("stream_occ_one", occupancy, 1);
    end
    checkOutput("wrap_count_255", commitCount, 255);
    applyStimulus(1'b0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_count_0", commitCount, 0);
    checkOutput("wrap_occ_empty", occupancy, 0);
    checkOutput("wrap_status", statusFlags, 4'b1111);
    readAddrA = 3'd7;
    readAddrB = 3'd6;
    #1;
    checkOutput("wrap_r7", readDataA, 8'hA5);
    checkOutput("wrap_r6", readDataB, 8'hA4);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
